// File: rtl/systolic_tile_sequencer.sv
//------------------------------------------------------------------------------
// Module  : systolic_tile_sequencer
// Brief   : Clear/feed/drain sequencer for an NxN output-stationary systolic array.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module systolic_tile_sequencer #(
  parameter int N  = 4,
  parameter int AW = 6,
  parameter int RW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ap_start,
  input  logic            stop,
  input  logic [1:0]      mode,
  input  logic [AW:0]     k_len,
  output logic [N-1:0]    rd_en_a,
  output logic [N*AW-1:0] rd_addr_a,
  output logic [N-1:0]    rd_en_b,
  output logic [N*AW-1:0] rd_addr_b,
  output logic            pe_clear,
  output logic            pe_en,
  output logic [RW-1:0]   res_row_sel,
  output logic [7:0]      base_addr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic            busy,
  output logic            done,
  output logic            aborted
);

  // Wide enough for K up to 2^AW plus the 2N-3 cycles of skew.
  localparam int CW = AW + 6;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [AW:0]     k_q, k_d;
  logic [CW-1:0]   c_q, c_d;
  logic [RW-1:0]   r_q, r_d;
  logic            aborted_d;

  logic [N-1:0]    en_q, en_d;
  logic [N*AW-1:0] addr_q, addr_d;
  logic            pe_clear_q, pe_en_q, out_valid_q, out_last_q;
  logic            busy_q, done_q, aborted_q;
  logic [RW-1:0]   row_sel_q, row_sel_d;
  logic [7:0]      base_q, base_d;

  logic [CW-1:0]   kx_q, kx_d, c_last;

  assign kx_q   = {{(CW-AW-1){1'b0}}, k_q};
  assign kx_d   = {{(CW-AW-1){1'b0}}, k_d};
  assign c_last = kx_q + CW'(2*N-3);

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    c_d       = c_q;
    r_d       = r_q;
    aborted_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ap_start && !stop) begin
          k_d = k_len;
          c_d = '0;
          r_d = '0;
          case (mode)
            2'b00:   state_d = S_CLEAR;
            2'b01:   state_d = (k_len == '0) ? S_DRAIN : S_FEED;
            2'b10:   state_d = S_DRAIN;
            default: state_d = S_FIN;
          endcase
        end
      end
      S_CLEAR: state_d = (k_q == '0) ? S_DRAIN : S_FEED;
      S_FEED: begin
        if (c_q == c_last) begin
          state_d = S_DRAIN;
        end else begin
          c_d = c_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (r_q == RW'(N-1)) begin
            state_d = S_FIN;
          end else begin
            r_d = r_q + RW'(1);
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (stop && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      aborted_d = 1'b1;
    end
  end

  // Output registers are loaded from next-state values so every output is a flop.
  generate
    for (genvar i = 0; i < N; i++) begin : g_lane
      assign en_d[i] = (state_d == S_FEED) && (c_d >= CW'(i)) && (c_d < (CW'(i) + kx_d));
      assign addr_d[i*AW +: AW] = en_d[i] ? AW'(c_d - CW'(i)) : '0;
    end
  endgenerate

  assign row_sel_d = (state_d == S_DRAIN) ? r_d : '0;
  assign base_d    = (state_d == S_DRAIN) ? (8'(r_d) * 8'(N)) : 8'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      c_q         <= '0;
      r_q         <= '0;
      en_q        <= '0;
      addr_q      <= '0;
      pe_clear_q  <= 1'b0;
      pe_en_q     <= 1'b0;
      row_sel_q   <= '0;
      base_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      c_q         <= c_d;
      r_q         <= r_d;
      en_q        <= en_d;
      addr_q      <= addr_d;
      pe_clear_q  <= (state_d == S_CLEAR);
      pe_en_q     <= (state_d == S_FEED);
      row_sel_q   <= row_sel_d;
      base_q      <= base_d;
      out_valid_q <= (state_d == S_DRAIN);
      out_last_q  <= (state_d == S_DRAIN) && (r_d == RW'(N-1));
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_FIN);
      aborted_q   <= aborted_d;
    end
  end

  // A row i and B column i share the same skew, so both banks see one schedule.
  assign rd_en_a     = en_q;
  assign rd_en_b     = en_q;
  assign rd_addr_a   = addr_q;
  assign rd_addr_b   = addr_q;
  assign pe_clear    = pe_clear_q;
  assign pe_en       = pe_en_q;
  assign res_row_sel = row_sel_q;
  assign base_addr   = base_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign aborted     = aborted_q;

endmodule

`default_nettype wire

// File: tb/tb_systolic_tile_sequencer.sv
//------------------------------------------------------------------------------
// Module  : tb_systolic_tile_sequencer
// Brief   : Directed self-checking bench for systolic_tile_sequencer (N=4 and N=8).
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_systolic_tile_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        ap_start = 1'b0, stop = 1'b0, out_ready = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic [6:0]  k_len = 7'd0;
  logic [3:0]  rd_en_a, rd_en_b;
  logic [23:0] rd_addr_a, rd_addr_b;
  logic        pe_clear, pe_en, out_valid, out_last, busy, done, aborted;
  logic [1:0]  res_row_sel;
  logic [7:0]  base_addr;

  logic        ap_start8 = 1'b0, stop8 = 1'b0, out_ready8 = 1'b1;
  logic [1:0]  mode8 = 2'b00;
  logic [6:0]  k_len8 = 7'd0;
  logic [7:0]  rd_en_a8, rd_en_b8;
  logic [47:0] rd_addr_a8, rd_addr_b8;
  logic        pe_clear8, pe_en8, out_valid8, out_last8, busy8, done8, aborted8;
  logic [2:0]  res_row_sel8;
  logic [7:0]  base_addr8;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  systolic_tile_sequencer #(.N(4), .AW(6)) u_dut4 (
    .clk(clk), .rst(rst), .ap_start(ap_start), .stop(stop), .mode(mode), .k_len(k_len),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b),
    .pe_clear(pe_clear), .pe_en(pe_en), .res_row_sel(res_row_sel), .base_addr(base_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done), .aborted(aborted)
  );

  systolic_tile_sequencer #(.N(8), .AW(6)) u_dut8 (
    .clk(clk), .rst(rst), .ap_start(ap_start8), .stop(stop8), .mode(mode8), .k_len(k_len8),
    .rd_en_a(rd_en_a8), .rd_addr_a(rd_addr_a8), .rd_en_b(rd_en_b8), .rd_addr_b(rd_addr_b8),
    .pe_clear(pe_clear8), .pe_en(pe_en8), .res_row_sel(res_row_sel8), .base_addr(base_addr8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_last(out_last8),
    .busy(busy8), .done(done8), .aborted(aborted8)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 1 of the job (one edge after ap_start was sampled).
  task automatic start4(input logic [1:0] m, input logic [6:0] k);
    mode     = m;
    k_len    = k;
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    #12;
    chk("reset_ctl", {rd_en_a, rd_en_b, pe_clear, pe_en, out_valid, out_last, busy, done, aborted,
                      res_row_sel, base_addr}, 64'd0);
    chk("reset_addr", {rd_addr_a, rd_addr_b}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Job 1: N=4, K=4, mode 00, no backpressure.
    out_ready = 1'b1;
    start4(2'b00, 7'd4);
    for (int t = 1; t <= 17; t++) begin
      chk($sformatf("j1 pe_clear t%0d", t), pe_clear, (t == 1));
      chk($sformatf("j1 pe_en t%0d", t), pe_en, (t >= 2 && t <= 11));
      chk($sformatf("j1 busy t%0d", t), busy, (t <= 16));
      chk($sformatf("j1 done t%0d", t), done, (t == 16));
      chk($sformatf("j1 valid t%0d", t), out_valid, (t >= 12 && t <= 15));
      chk($sformatf("j1 lane3_en t%0d", t), rd_en_a[3], (t >= 5 && t <= 8));
      chk($sformatf("j1 lane3_en_b t%0d", t), rd_en_b[3], (t >= 5 && t <= 8));
      chk($sformatf("j1 lane3_addr t%0d", t), rd_addr_a[23:18], (t >= 5 && t <= 8) ? (t - 5) : 0);
      if (t >= 12 && t <= 15) begin
        chk($sformatf("j1 base t%0d", t), base_addr, (t - 12) * 4);
        chk($sformatf("j1 row t%0d", t), res_row_sel, t - 12);
        chk($sformatf("j1 last t%0d", t), out_last, (t == 15));
      end
      if (t == 2) begin
        chk("j1 en_c0", rd_en_a, 64'h1);
        chk("j1 addr_c0", rd_addr_a, 64'h0);
      end
      if (t == 5) begin
        chk("j1 en_c3", rd_en_a, 64'hf);
        chk("j1 addr_a_c3", rd_addr_a, {40'd0, 6'd0, 6'd1, 6'd2, 6'd3});
        chk("j1 addr_b_c3", rd_addr_b, {40'd0, 6'd0, 6'd1, 6'd2, 6'd3});
      end
      if (t == 11) chk("j1 en_c9", rd_en_a, 64'h0);
      tick();
    end

    // Job 2: same job, row 1 held off for three cycles.
    start4(2'b00, 7'd4);
    for (int t = 1; t <= 20; t++) begin
      out_ready = !(t >= 13 && t <= 15);
      if (t >= 13 && t <= 16) begin
        chk($sformatf("bp row t%0d", t), res_row_sel, 64'd1);
        chk($sformatf("bp base t%0d", t), base_addr, 64'd4);
        chk($sformatf("bp valid t%0d", t), out_valid, 64'd1);
      end
      if (t == 17) chk("bp row2", res_row_sel, 64'd2);
      chk($sformatf("bp done t%0d", t), done, (t == 19));
      tick();
    end
    out_ready = 1'b1;

    // Job 3: stop at feed c=5 (cycle 7), then a fresh drain-only job.
    start4(2'b00, 7'd4);
    for (int t = 1; t <= 6; t++) tick();
    chk("stop pre_pe_en", pe_en, 64'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop aborted", aborted, 64'd1);
    chk("stop idle", {busy, pe_en, pe_clear, done, out_valid}, 64'd0);
    chk("stop en", {rd_en_a, rd_en_b}, 64'd0);
    seen = 0;
    tick();
    chk("stop aborted_once", aborted, 64'd0);
    for (int t = 0; t < 20; t++) begin
      if (done || busy) seen++;
      tick();
    end
    chk("stop no_done", seen, 64'd0);
    start4(2'b10, 7'd4);
    chk("m10 valid_c1", out_valid, 64'd1);
    chk("m10 row_c1", res_row_sel, 64'd0);
    chk("m10 clear_c1", pe_clear, 64'd0);
    for (int t = 1; t <= 4; t++) tick();
    chk("m10 done_c5", done, 64'd1);
    tick();

    // Job 4: mode 01, K=2; inputs changed after start, stray ap_start mid-job.
    start4(2'b01, 7'd2);
    mode  = 2'b11;
    k_len = 7'd9;
    for (int t = 1; t <= 14; t++) begin
      ap_start = (t == 3);
      chk($sformatf("m01 clear t%0d", t), pe_clear, 64'd0);
      chk($sformatf("m01 pe_en t%0d", t), pe_en, (t <= 8));
      chk($sformatf("m01 lane1 t%0d", t), rd_en_a[1], (t == 2 || t == 3));
      chk($sformatf("m01 done t%0d", t), done, (t == 13));
      chk($sformatf("m01 busy t%0d", t), busy, (t <= 13));
      tick();
    end
    ap_start = 1'b0;

    // Mode 11: done in cycle 1 only.
    start4(2'b11, 7'd3);
    chk("m11 done_c1", done, 64'd1);
    chk("m11 busy_c1", busy, 64'd1);
    tick();
    chk("m11 done_c2", done, 64'd0);
    chk("m11 busy_c2", busy, 64'd0);

    // ap_start together with stop in IDLE does nothing.
    mode = 2'b00; k_len = 7'd4; ap_start = 1'b1; stop = 1'b1;
    tick();
    ap_start = 1'b0; stop = 1'b0;
    chk("startstop idle", {busy, aborted, pe_clear, done}, 64'd0);

    // K=0, mode 00: CLEAR then straight to DRAIN.
    start4(2'b00, 7'd0);
    for (int t = 1; t <= 7; t++) begin
      chk($sformatf("k0 clear t%0d", t), pe_clear, (t == 1));
      chk($sformatf("k0 en t%0d", t), {rd_en_a, rd_en_b, pe_en}, 64'd0);
      chk($sformatf("k0 valid t%0d", t), out_valid, (t >= 2 && t <= 5));
      chk($sformatf("k0 done t%0d", t), done, (t == 6));
      tick();
    end

    // N=8, K=1: 15-cycle FEED, one lane per cycle; reset mid-DRAIN.
    mode8 = 2'b00; k_len8 = 7'd1; ap_start8 = 1'b1;
    tick();
    ap_start8 = 1'b0;
    for (int t = 1; t <= 18; t++) begin
      chk($sformatf("n8 pe_en t%0d", t), pe_en8, (t >= 2 && t <= 16));
      chk($sformatf("n8 en t%0d", t), rd_en_a8, (t >= 2 && t <= 9) ? (64'd1 << (t - 2)) : 64'd0);
      chk($sformatf("n8 valid t%0d", t), out_valid8, (t >= 17));
      if (t == 18) chk("n8 base_row1", base_addr8, 64'd8);
      if (t < 18) tick();
    end
    #3;
    rst = 1'b0;
    #1;
    chk("n8 async_rst_ctl", {rd_en_a8, pe_clear8, pe_en8, out_valid8, out_last8, busy8, done8,
                             aborted8, res_row_sel8, base_addr8}, 64'd0);
    chk("n8 async_rst_addr", rd_addr_a8, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (busy8 || done8 || aborted8 || out_valid8) seen++;
    end
    chk("n8 post_rst_idle", seen, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
